rm_swlw_sequencer: RTL

- Feeds the sw/lw runtime-monitor automata array with instruction-event symbols from the commit stage.
- Buffers events in a small FIFO and drives the monitor's run/symbols/reset inputs one symbol at a time.
- Samples the four LTL violation outputs after each symbol and folds them into sticky status, a violation counter and an interrupt line.
- Sits between the commit-side event tap and the monitor top level.

---
 rtl/rm_swlw_sequencer.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/rm_swlw_sequencer.sv
// rm_swlw_sequencer
//
// Feeds the sw/lw runtime-monitor automata array with instruction-event
// symbols taken from the commit stage. Events are buffered in a small FIFO and
// presented to the monitor one symbol at a time. Each symbol uses a FEED cycle
// (mon_run high) and then a CHECK cycle that samples the monitor's LTL
// violation outputs. The sampled violations are folded into sticky status, a
// saturating violation counter and a registered interrupt line.
//
// Ports:
//   clk          single clock
//   reset        synchronous, active-high reset
//   enable       allows FIFO pops toward the monitor
//   ev_valid     event offered by the commit-side tap
//   ev_ready     event accepted when ev_valid & ev_ready
//   ev_symbol    event symbol (SYM_W bits)
//   ev_flush     one-cycle request: drop queued events and reset the automata
//   mon_run      registered, monitor run strobe
//   mon_symbols  registered, monitor input symbol
//   mon_reset    registered, monitor reset
//   mon_viol     monitor violation outputs, bit i = ltl{i}
//   clr          clears viol_sticky and viol_count
//   viol_sticky  accumulated violations
//   viol_count   saturating count of symbols that produced any violation
//   irq          registered, equals |viol_sticky one cycle later
//   busy         FSM not idle or FIFO non-empty
module rm_swlw_sequencer #(
  parameter int unsigned SYM_W      = 8,
  parameter int unsigned NUM_PROP   = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                ev_valid,
  output logic                ev_ready,
  input  logic [SYM_W-1:0]    ev_symbol,
  input  logic                ev_flush,
  output logic                mon_run,
  output logic [SYM_W-1:0]    mon_symbols,
  output logic                mon_reset,
  input  logic [NUM_PROP-1:0] mon_viol,
  input  logic                clr,
  output logic [NUM_PROP-1:0] viol_sticky,
  output logic [15:0]         viol_count,
  output logic                irq,
  output logic                busy
);

  // ---------------------------------------------------------------------------
  // Local sizing
  // ---------------------------------------------------------------------------
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned RcW  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [RcW-1:0]  RcInit   = RcW'(RST_CYCLES - 1);
  localparam logic [CntW-1:0] FifoFull = CntW'(FIFO_DEPTH);

  // FSM encoding
  localparam logic [1:0] StRstMon = 2'd0;
  localparam logic [1:0] StIdle   = 2'd1;
  localparam logic [1:0] StFeed   = 2'd2;
  localparam logic [1:0] StCheck  = 2'd3;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]          state_q, state_d;
  logic [RcW-1:0]      rst_cnt_q, rst_cnt_d;

  logic [SYM_W-1:0]    mem_q [FIFO_DEPTH];
  logic [SYM_W-1:0]    mem_d [FIFO_DEPTH];
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]     fifo_cnt_q, fifo_cnt_d;

  logic                mon_run_q, mon_run_d;
  logic [SYM_W-1:0]    mon_symbols_q, mon_symbols_d;
  logic                mon_reset_q, mon_reset_d;

  logic [NUM_PROP-1:0] viol_sticky_q, viol_sticky_d;
  logic [15:0]         viol_count_q, viol_count_d;
  logic                irq_q, irq_d;

  // ---------------------------------------------------------------------------
  // FIFO status and handshake
  // ---------------------------------------------------------------------------
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic fifo_clear;
  logic check;

  assign fifo_full  = (fifo_cnt_q == FifoFull);
  assign fifo_empty = (fifo_cnt_q == '0);

  // The flush cycle never accepts, so a flush cannot race a push into the FIFO.
  assign ev_ready = !fifo_full && (state_q != StRstMon) && !ev_flush;
  assign push     = ev_valid && ev_ready;

  // ---------------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    mon_run_d     = 1'b0;
    mon_symbols_d = mon_symbols_q;
    mon_reset_d   = 1'b0;
    pop           = 1'b0;
    fifo_clear    = 1'b0;
    check         = 1'b0;

    unique case (state_q)
      StRstMon: begin
        fifo_clear  = 1'b1;
        mon_reset_d = 1'b1;
        if (ev_flush) begin
          // A flush while already resetting restarts the hold period.
          rst_cnt_d = RcInit;
        end else if (rst_cnt_q == '0) begin
          state_d     = StIdle;
          mon_reset_d = 1'b0;
        end else begin
          rst_cnt_d = rst_cnt_q - RcW'(1);
        end
      end

      StIdle: begin
        if (ev_flush) begin
          state_d     = StRstMon;
          rst_cnt_d   = RcInit;
          mon_reset_d = 1'b1;
          fifo_clear  = 1'b1;
        end else if (enable && !fifo_empty) begin
          pop           = 1'b1;
          state_d       = StFeed;
          mon_run_d     = 1'b1;
          mon_symbols_d = mem_q[rd_ptr_q];
        end
      end

      StFeed: begin
        // A flush here abandons the symbol: it is never checked.
        if (ev_flush) begin
          state_d     = StRstMon;
          rst_cnt_d   = RcInit;
          mon_reset_d = 1'b1;
          fifo_clear  = 1'b1;
        end else begin
          state_d = StCheck;
        end
      end

      StCheck: begin
        // Sampling always completes, even when a flush arrives in this cycle.
        check = 1'b1;
        if (ev_flush) begin
          state_d     = StRstMon;
          rst_cnt_d   = RcInit;
          mon_reset_d = 1'b1;
          fifo_clear  = 1'b1;
        end else if (enable && !fifo_empty) begin
          pop           = 1'b1;
          state_d       = StFeed;
          mon_run_d     = 1'b1;
          mon_symbols_d = mem_q[rd_ptr_q];
        end else begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d     = StRstMon;
        rst_cnt_d   = RcInit;
        mon_reset_d = 1'b1;
        fifo_clear  = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO next state
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = ev_symbol;
    end
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (fifo_clear) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fifo_cnt_d = '0;
    end else begin
      // Depth is a power of two, so the pointers wrap naturally.
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      fifo_cnt_d = fifo_cnt_q + CntW'(push) - CntW'(pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Violation status
  // ---------------------------------------------------------------------------
  always_comb begin
    viol_sticky_d = clr ? '0 : viol_sticky_q;
    viol_count_d  = clr ? '0 : viol_count_q;
    if (check) begin
      viol_sticky_d = viol_sticky_d | mon_viol;
      if ((mon_viol != '0) && (viol_count_d != 16'hFFFF)) begin
        viol_count_d = viol_count_d + 16'd1;
      end
    end
    irq_d = |viol_sticky_q;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StRstMon;
      rst_cnt_q     <= RcInit;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      mon_run_q     <= 1'b0;
      mon_symbols_q <= '0;
      mon_reset_q   <= 1'b1;
      viol_sticky_q <= '0;
      viol_count_q  <= '0;
      irq_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      mon_run_q     <= mon_run_d;
      mon_symbols_q <= mon_symbols_d;
      mon_reset_q   <= mon_reset_d;
      viol_sticky_q <= viol_sticky_d;
      viol_count_q  <= viol_count_d;
      irq_q         <= irq_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mon_run     = mon_run_q;
  assign mon_symbols = mon_symbols_q;
  assign mon_reset   = mon_reset_q;
  assign viol_sticky = viol_sticky_q;
  assign viol_count  = viol_count_q;
  assign irq         = irq_q;
  assign busy        = (state_q != StIdle) || !fifo_empty;

endmodule
